lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Load/store unit on the initiator side of the byte-addressed data memory port (funct3 select, read/write strobes, 8-bit address, 32-bit data in/out).
- Sits in the MEM stage. Accepts one load/store request from the pipeline over a valid/ready handshake and checks it for legality.
- Drives the memory port for exactly one cycle, then returns the load data or an error code over a valid/ready response channel.

Parameters:
- ADDR_W, 32, width of the pipeline effective address.
- MEM_AW, 8, memory port address width.
- MEM_BYTES, 256, size of the addressable memory in bytes.
- CHECK_ALIGN, 1, when 1, halfword/word accesses must be naturally aligned.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (F3_LB..F3_LHU, F3_SB..F3_SW).
- req_addr  in  ADDR_W  effective byte address.
- req_wdata  in  32  store data (low bytes used for sb/sh).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  load result, already extended by memory; 0 for stores and errors.
- rsp_err  out  2  00 ok, 01 misaligned, 10 access fault, 11 illegal funct3.
- mem_choose  out  3  funct3 to memory.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  MEM_AW  memory byte address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  combinational memory read data.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=00. mem_read, mem_write, mem_choose, mem_addr and mem_wdata are all 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. When req_valid && req_ready at an edge, the unit registers we, funct3, addr and wdata.
  - No error: go to ACCESS.
  - Error: go to RESP with rsp_err set and rsp_rdata=0. The memory port is never strobed.
- Legality checks, priority order, highest first:
  - Illegal funct3: a load with funct3 in {3,6,7}, or a store with funct3 > 2.
  - Misaligned (CHECK_ALIGN=1 only): halfword with addr[0]≠0, or word with addr[1:0]≠0.
  - Access fault: addr + size − 1 ≥ MEM_BYTES. No wrap-around. Upper address bits above MEM_AW must be zero.
- ACCESS: lasts exactly 1 cycle.
  - Outputs: mem_choose=funct3, mem_addr=addr[MEM_AW-1:0], mem_wdata=wdata.
  - Load: mem_read=1 and mem_write=0. mem_rdata is captured into rsp_rdata at the closing edge.
  - Store: mem_write=1 and mem_read=0. The memory commits on that same edge. rsp_rdata=0.
  - Always go to RESP.
- Outside ACCESS, mem_read=mem_write=0 registered-low. A store's write strobe is never high for more than one edge.
- RESP: rsp_valid=1 and req_ready=0.
  - rsp_rdata and rsp_err hold stable until rsp_valid && rsp_ready.
  - On handshake, go to IDLE.
  - A new request can be accepted one cycle after the response handshake. No same-cycle overlap.
- Latency: request accepted at edge N; rsp_valid visible from cycle N+2 for a legal access, N+1 for an erroring one.
- Byte order is defined by the memory: the byte at mem_addr is the MSB of a halfword or word. The unit does no data shifting or extension.
- Reset mid-operation: all state and outputs return to reset values asynchronously. A pending response is dropped. A store interrupted in ACCESS before the edge does not commit.
- rsp_ready high while rsp_valid is low is ignored.

Decomposition:
- Shared defines file:
  - Already holds the F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW constants.
  - Add LSU_ERR_OK, LSU_ERR_MISAL, LSU_ERR_FAULT, LSU_ERR_ILL and the FSM state encodings.
- One sub-module, lsu_req_check: combinational legality checker. Inputs we, funct3, addr; output err code. Shared with future fetch-side checking.

Test Plan:
- lw at addr 248 with the memory word = 9 → rsp_valid at N+2, rsp_rdata=0x00000009, rsp_err=00, exactly one mem_read cycle.
- sb wdata=0x000000A5 at addr 100, then lbu 100 → 0x000000A5, then lb 100 → 0xFFFFFFA5. The store shows exactly one mem_write cycle.
- lw at addr 0x102 → rsp_err=01 at N+1; mem_read and mem_write never asserted. lh at 0x101 → 01.
- lw at 0x100, and sh at 0x1FE → rsp_err=10. Load funct3=3 → 11, even when misaligned (priority check).
- lw issued with rsp_ready held low 3 cycles → rsp_rdata/rsp_err stable, req_ready=0 throughout. After the handshake, the next request is accepted one cycle later.
- sw of 0xDEADBEEF to addr 64 with rst_n pulsed low mid-ACCESS before the edge → mem_write drops immediately, rsp_valid=0, word at 64 unchanged.

Source files
------------

// File: rtl/lsu_mem_master_pkg.sv
// Shared load/store definitions: funct3 encodings, error codes, FSM states,
// response record and an access-size helper.
package lsu_mem_master_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam logic [1:0] LSU_ERR_OK    = 2'b00;
  localparam logic [1:0] LSU_ERR_MISAL = 2'b01;
  localparam logic [1:0] LSU_ERR_FAULT = 2'b10;
  localparam logic [1:0] LSU_ERR_ILL   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  err;
  } lsu_rsp_t;

  // Bytes touched by an access; funct3[1:0] encodes byte/half/word.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'd0:    access_size = 3'd1;
      2'd1:    access_size = 3'd2;
      default: access_size = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_master_req_check.sv
// Combinational legality check for a load/store request.
// Priority: illegal funct3 > misaligned > access fault.
module lsu_req_check
  import lsu_mem_master_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int MEM_AW      = 8,
  parameter int MEM_BYTES   = 256,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  output logic [1:0]        err
);

  // One extra bit so addr + size - 1 can never wrap back into range.
  localparam logic [ADDR_W:0] MEM_END = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  logic            ill, mis, fault;
  logic [2:0]      size;
  logic [ADDR_W:0] last;

  // Evaluate each rule, then pick the highest-priority one.
  always_comb begin
    size  = access_size(funct3);
    ill   = we ? (funct3 > F3_SW)
               : (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
    mis   = 1'b0;
    if (CHECK_ALIGN)
      mis = (size == 3'd2 && addr[0]) || (size == 3'd4 && addr[1:0] != 2'b00);
    last  = {1'b0, addr} + (ADDR_W+1)'(size) - ONE;
    fault = (last >= MEM_END) || ((addr >> MEM_AW) != '0);
    if (ill)        err = LSU_ERR_ILL;
    else if (mis)   err = LSU_ERR_MISAL;
    else if (fault) err = LSU_ERR_FAULT;
    else            err = LSU_ERR_OK;
  end

endmodule

// File: rtl/lsu_mem_master.sv
// MEM-stage load/store master: accepts one request, checks it, strobes the
// memory port for a single cycle and returns data or an error code.
module lsu_mem_master
  import lsu_mem_master_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int MEM_AW      = 8,
  parameter int MEM_BYTES   = 256,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic [2:0]        mem_choose,
  output logic              mem_read,
  output logic              mem_write,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state, state_nxt;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [MEM_AW-1:0] addr_q;
  logic [31:0]       wdata_q;
  lsu_rsp_t          rsp_q;
  logic [1:0]        chk_err;
  logic              accept, rsp_done;

  lsu_req_check #(
    .ADDR_W      (ADDR_W),
    .MEM_AW      (MEM_AW),
    .MEM_BYTES   (MEM_BYTES),
    .CHECK_ALIGN (CHECK_ALIGN)
  ) u_check (
    .we     (req_we),
    .funct3 (req_funct3),
    .addr   (req_addr),
    .err    (chk_err)
  );

  assign accept    = req_valid && req_ready;
  assign rsp_done  = rsp_valid && rsp_ready;
  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state: errors skip the memory access entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = (chk_err == LSU_ERR_OK) ? ST_ACCESS : ST_RESP;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   if (rsp_done) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register; memory port is zero outside ACCESS.
  always_comb begin
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_choose = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      ST_IDLE: req_ready = 1'b1;
      ST_ACCESS: begin
        mem_read   = !we_q;
        mem_write  = we_q;
        mem_choose = f3_q;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
      end
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request capture on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr[MEM_AW-1:0];
      wdata_q <= req_wdata;
    end
  end

  // Response: error latched at accept, load data at the end of ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q <= '0;
    end else if (accept) begin
      rsp_q <= '{rdata: '0, err: chk_err};
    end else if (state == ST_ACCESS) begin
      rsp_q.rdata <= we_q ? '0 : mem_rdata;
    end else if (rsp_done) begin
      rsp_q <= '0;
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: big-endian byte memory, table of directed
// vectors, random requests against a byte-array model, stall and reset cases.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [2:0]  mem_choose;
  logic        mem_read, mem_write;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_mem_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_choose(mem_choose), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory the DUT talks to: MSB-first, extension done here.
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] b0, b1, b2, b3;

  always_comb begin
    b0 = mem[mem_addr];
    b1 = mem[mem_addr + 8'd1];
    b2 = mem[mem_addr + 8'd2];
    b3 = mem[mem_addr + 8'd3];
    mem_rdata = '0;
    case (mem_choose)
      3'd0: mem_rdata = {{24{b0[7]}}, b0};
      3'd1: mem_rdata = {{16{b0[7]}}, b0, b1};
      3'd2: mem_rdata = {b0, b1, b2, b3};
      3'd4: mem_rdata = {24'h0, b0};
      3'd5: mem_rdata = {16'h0, b0, b1};
      default: mem_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_write) begin
      case (mem_choose[1:0])
        2'd0: mem[mem_addr] <= mem_wdata[7:0];
        2'd1: begin
          mem[mem_addr]        <= mem_wdata[15:8];
          mem[mem_addr + 8'd1] <= mem_wdata[7:0];
        end
        default: begin
          mem[mem_addr]        <= mem_wdata[31:24];
          mem[mem_addr + 8'd1] <= mem_wdata[23:16];
          mem[mem_addr + 8'd2] <= mem_wdata[15:8];
          mem[mem_addr + 8'd3] <= mem_wdata[7:0];
        end
      endcase
    end
  end

  // Reference model: a plain byte array plus arithmetic legality rules.
  logic [7:0] ref_mem [256];

  function automatic int ref_size(logic [2:0] f3);
    return (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
  endfunction

  function automatic logic [1:0] ref_err(logic we, logic [2:0] f3, logic [31:0] a);
    longint last;
    int sz;
    if (we ? (f3 > 2) : (f3 == 3 || f3 > 5)) return 2'b11;
    sz = ref_size(f3);
    if (longint'(a) % sz != 0) return 2'b01;
    last = longint'(a) + sz - 1;
    if (last >= 256) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] a);
    logic [31:0] v = 0;
    for (int i = 0; i < ref_size(f3); i++) v = (v << 8) | 32'(ref_mem[a + i]);
    if (f3 == 0 && v[7])  v = v | 32'hFFFFFF00;
    if (f3 == 1 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  function automatic void ref_store(logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    int sz = ref_size(f3);
    for (int i = 0; i < sz; i++) ref_mem[a + i] = 8'(wd >> (8 * (sz - 1 - i)));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One transaction from a negedge; returns at the negedge after the handshake.
  task automatic run(input string nm, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input int stall,
                     input logic [1:0] eerr, input logic [31:0] erd);
    int g = 0, lat = 0, nr = 0, nw = 0;
    bit port_ok = 1;
    logic [31:0] rd;
    logic [1:0]  er;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    chk({nm, "_ready"}, 32'(req_ready), 32'd1);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    do begin
      @(negedge clk); lat++;
      if (mem_read)  nr++;
      if (mem_write) nw++;
      if ((mem_read || mem_write) &&
          (mem_addr !== a[7:0] || mem_choose !== f3 || (we && mem_wdata !== wd)))
        port_ok = 0;
    end while (!rsp_valid && lat < 20);
    chk({nm, "_lat"}, 32'(lat), (eerr == 2'b00) ? 32'd2 : 32'd1);
    if (!rsp_valid) return;
    rd = rsp_rdata; er = rsp_err;
    chk({nm, "_err"}, 32'(er), 32'(eerr));
    chk({nm, "_rdata"}, rd, erd);
    chk({nm, "_nread"},  32'(nr), (eerr == 2'b00 && !we) ? 32'd1 : 32'd0);
    chk({nm, "_nwrite"}, 32'(nw), (eerr == 2'b00 && we) ? 32'd1 : 32'd0);
    chk({nm, "_port"}, 32'(port_ok), 32'd1);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({nm, "_hold"}, {rsp_rdata[29:0], rsp_err}, {rd[29:0], er});
      chk({nm, "_hold_hs"}, {30'd0, rsp_valid, req_ready}, 32'b10);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_idle"}, {30'd0, rsp_valid, req_ready}, 32'b01);
    if (ref_err(we, f3, a) == 2'b00 && we) ref_store(f3, a, wd);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  err;
    logic [31:0] rd;
  } vec_t;

  vec_t tv[$];

  initial begin
    logic        rwe;
    logic [2:0]  rf3;
    logic [31:0] ra, rwd, erd;
    logic [1:0]  eer;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    tv.push_back('{1'b1, 3'd2, 32'd248,        32'd9,        2'b00, 32'h0});
    tv.push_back('{1'b0, 3'd2, 32'd248,        32'd0,        2'b00, 32'h00000009});
    tv.push_back('{1'b1, 3'd0, 32'd100,        32'h000000A5, 2'b00, 32'h0});
    tv.push_back('{1'b0, 3'd4, 32'd100,        32'd0,        2'b00, 32'h000000A5});
    tv.push_back('{1'b0, 3'd0, 32'd100,        32'd0,        2'b00, 32'hFFFFFFA5});
    tv.push_back('{1'b1, 3'd2, 32'd0,          32'h80010203, 2'b00, 32'h0});
    tv.push_back('{1'b0, 3'd1, 32'd0,          32'd0,        2'b00, 32'hFFFF8001});
    tv.push_back('{1'b0, 3'd5, 32'd2,          32'd0,        2'b00, 32'h00000203});
    tv.push_back('{1'b1, 3'd2, 32'd252,        32'hCAFEBABE, 2'b00, 32'h0});
    tv.push_back('{1'b0, 3'd2, 32'd252,        32'd0,        2'b00, 32'hCAFEBABE});
    tv.push_back('{1'b0, 3'd0, 32'd255,        32'd0,        2'b00, 32'hFFFFFFBE});
    tv.push_back('{1'b0, 3'd5, 32'd254,        32'd0,        2'b00, 32'h0000BABE});
    tv.push_back('{1'b0, 3'd2, 32'h102,        32'd0,        2'b01, 32'h0});
    tv.push_back('{1'b0, 3'd1, 32'h101,        32'd0,        2'b01, 32'h0});
    tv.push_back('{1'b0, 3'd2, 32'd253,        32'd0,        2'b01, 32'h0});
    tv.push_back('{1'b0, 3'd1, 32'd255,        32'd0,        2'b01, 32'h0});
    tv.push_back('{1'b0, 3'd2, 32'h100,        32'd0,        2'b10, 32'h0});
    tv.push_back('{1'b1, 3'd1, 32'h1FE,        32'h1234,     2'b10, 32'h0});
    tv.push_back('{1'b0, 3'd2, 32'hFFFFFFFC,   32'd0,        2'b10, 32'h0});
    tv.push_back('{1'b0, 3'd3, 32'h101,        32'd0,        2'b11, 32'h0});
    tv.push_back('{1'b1, 3'd5, 32'd0,          32'd0,        2'b11, 32'h0});

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp",   {rsp_rdata[29:0], rsp_err}, 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mem",   {mem_wdata[23:0], mem_addr}, 32'd0);
    chk("rst_strb",  {27'd0, mem_choose, mem_read, mem_write}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tv[i])
      run($sformatf("tv%0d", i), tv[i].we, tv[i].f3, tv[i].addr, tv[i].wd, 0,
          tv[i].err, tv[i].rd);

    for (int i = 0; i < 60; i++) begin
      rwe = 1'($urandom_range(0, 1));
      rf3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0, 1:    ra = $urandom_range(0, 255);
        2:       ra = $urandom_range(240, 300);
        default: ra = $urandom;
      endcase
      rwd = $urandom;
      eer = ref_err(rwe, rf3, ra);
      erd = (eer == 2'b00 && !rwe) ? ref_load(rf3, ra) : 32'h0;
      run($sformatf("rnd%0d", i), rwe, rf3, ra, rwd, $urandom_range(0, 2), eer, erd);
    end

    // Response back-pressure: held three cycles, then back-to-back request.
    run("stall", 1'b0, 3'd2, 32'd248, 32'd0, 3, 2'b00, ref_load(3'd2, 32'd248));
    run("after_stall", 1'b0, 3'd4, 32'd100, 32'd0, 0, 2'b00, ref_load(3'd4, 32'd100));

    // Reset during a store's ACCESS cycle must not commit the store.
    run("pre_rst_sw", 1'b1, 3'd2, 32'd64, 32'h11223344, 0, 2'b00, 32'h0);
    req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'd64;
    req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
    @(posedge clk); #2;
    chk("access_wr", 32'(mem_write), 32'd1);
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    chk("rst_mid_wr", 32'(mem_write), 32'd0);
    chk("rst_mid_vld", {30'd0, rsp_valid, req_ready}, 32'b01);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mem64", {mem[64], mem[65], mem[66], mem[67]}, 32'h11223344);
    run("post_rst_lw", 1'b0, 3'd2, 32'd64, 32'd0, 0, 2'b00, 32'h11223344);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
